// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and data-memory-wait hazard controller for the 5-stage RV32I pipeline.
// Optional cycle counters for each hazard group are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       id_ex_hold,
  output logic       ex_mem_hold,
  output logic       mem_wb_bubble,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
`endif
);
  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] REDIR = 2'b01;
  localparam logic [1:0] MEM_WAIT = 2'b10;
  localparam logic [3:0] RB1 = 4'(REDIRECT_BUBBLES - 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic MULTI = REDIRECT_BUBBLES > 1;
  localparam logic WDOG = MEM_TIMEOUT != 0;
  logic [1:0] state;
  logic [3:0] bub_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic resume, in_wait, in_redir, freeze, redir, load_use, fire;
  always_comb begin
    in_wait = state == MEM_WAIT;
    in_redir = state == REDIR;
    freeze = rst_n & (in_wait ? ~mem_ready : mem_req & ~mem_ready);
    redir = rst_n & ~freeze & (ex_redirect | in_redir);
    load_use = rst_n & ~freeze & ~redir & ex_mem_read & (|ex_rd) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    fire = in_wait & ~mem_ready & WDOG & (wait_cnt == TMO);
  end
  assign pc_stall = freeze | load_use;
  assign if_id_stall = freeze | load_use;
  assign id_ex_stall = load_use;
  assign if_id_flush = redir;
  assign id_ex_flush = redir;
  assign id_ex_hold = freeze;
  assign ex_mem_hold = freeze;
  assign mem_wb_bubble = freeze;
  // A freeze during REDIR parks the remaining bubble count and resumes it once memory answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      bub_cnt <= '0;
      wait_cnt <= '0;
      resume <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (fire) begin
      state <= RUN;
      resume <= 1'b0;
      wait_cnt <= '0;
      mem_timeout <= 1'b1;
    end else if (freeze) begin
      state <= MEM_WAIT;
      resume <= in_wait ? resume : in_redir;
      wait_cnt <= !in_wait ? CNT_W'(1) : (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
    end else if (in_wait) begin
      state <= (resume | (ex_redirect & MULTI)) ? REDIR : RUN;
      resume <= 1'b0;
      wait_cnt <= '0;
      bub_cnt <= ex_redirect ? RB1 : bub_cnt;
    end else if (ex_redirect) begin
      state <= MULTI ? REDIR : RUN;
      bub_cnt <= RB1;
    end else if (in_redir) begin
      state <= (bub_cnt == 4'd1) ? RUN : REDIR;
      bub_cnt <= bub_cnt - 1'b1;
    end else begin
      state <= RUN;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      redirect_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      load_stall_cnt <= (load_use & ~&load_stall_cnt) ? load_stall_cnt + 1'b1 : load_stall_cnt;
      redirect_cnt <= (redir & ~&redirect_cnt) ? redirect_cnt + 1'b1 : redirect_cnt;
      mem_wait_cnt <= (freeze & ~&mem_wait_cnt) ? mem_wait_cnt + 1'b1 : mem_wait_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized check of hazard_ctrl against a remaining-cycles reference model.
module tb_hazard_ctrl;
  localparam int RB = 2;
  localparam int MT = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_redirect = 0, mem_req = 0, mem_ready = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout;
  logic [8:0] outs;
  int n_chk = 0, n_fail = 0;
  bit waiting, tmo;
  int flush_left, pending, wait_cycles, n_lu, n_rd, n_fz;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] load_stall_cnt, redirect_cnt, mem_wait_cnt;
`endif
  hazard_ctrl #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .load_stall_cnt(load_stall_cnt), .redirect_cnt(redirect_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
  );
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 id_ex_hold, ex_mem_hold, mem_wb_bubble, mem_timeout};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_rst();
    waiting = 0; tmo = 0; flush_left = 0; pending = 0; wait_cycles = 0;
    n_lu = 0; n_rd = 0; n_fz = 0;
  endtask
  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_lu_cnt"}, 32'(load_stall_cnt), n_lu);
    chk({tag, "_rd_cnt"}, 32'(redirect_cnt), n_rd);
    chk({tag, "_fz_cnt"}, 32'(mem_wait_cnt), n_fz);
`else
    chk({tag, "_timeout_clr"}, 32'(mem_timeout), 32'(tmo));
`endif
  endtask
  task automatic step(input string tag, input logic [4:0] rs1, rs2, rd,
                      input logic u1, u2, mr, rdr, req, rdy);
    bit frz, rdn, lu, fire;
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_redirect = rdr; mem_req = req; mem_ready = rdy;
    #1;
    frz = waiting ? !rdy : (req && !rdy);
    rdn = !frz && (rdr || (!waiting && flush_left > 0));
    lu = !frz && !rdn && mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    fire = waiting && !rdy && MT != 0 && wait_cycles == MT;
    chk(tag, 32'(outs), 32'({frz | lu, frz | lu, rdn, lu, rdn, frz, frz, frz, tmo}));
    @(posedge clk);
    n_lu += int'(lu); n_rd += int'(rdn); n_fz += int'(frz);
    if (fire) begin
      tmo = 1; waiting = 0; pending = 0; flush_left = 0;
    end else if (frz) begin
      if (!waiting) begin
        waiting = 1; wait_cycles = 1; pending = flush_left; flush_left = 0;
      end else if (wait_cycles < (1 << CW) - 1) wait_cycles++;
    end else if (waiting) begin
      waiting = 0; flush_left = rdr ? RB - 1 : pending; pending = 0;
    end else if (rdr) flush_left = RB - 1;
    else if (flush_left > 0) flush_left--;
    @(negedge clk);
  endtask
  task automatic pulse_rst(input string tag);
    rst_n = 0;
    #1;
    chk({tag, "_outs"}, 32'(outs), 32'd0);
    model_rst();
    @(negedge clk);
    rst_n = 1;
    check_perf(tag);
  endtask
  initial begin
    model_rst();
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step("lu_hit",  5, 0, 5, 1, 0, 1, 0, 0, 1);
    step("lu_idle", 5, 0, 5, 1, 0, 0, 0, 0, 1);
    step("lu_x0",   0, 0, 0, 1, 0, 1, 0, 0, 1);
    step("lu_rs2",  1, 7, 7, 0, 1, 1, 0, 0, 1);
    step("redir_0", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("redir_1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("redir_2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("redir_lu", 3, 0, 3, 1, 0, 1, 1, 0, 1);
    step("redir_lu1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("wait", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wait_rdy", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("wait_run", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("redir_frz0", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("redir_frz1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("redir_frz2", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("redir_frz3", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("wdog", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wdog_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("wdog_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    pulse_rst("rst_after_wdog");
    step("mid_wait0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mid_wait1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    mem_req = 1; mem_ready = 0;
    pulse_rst("rst_mid_wait");
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_rst("rand_rst");
      step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) < ((i % 200) < 40 ? 1 : 6));
    end
    check_perf("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
